map_arb: RTL



---
 rtl/map_arb_if.sv | 38 +++
 rtl/map_arb.sv | 118 +++++++++++
 2 files changed

// File: rtl/map_arb_if.sv
// Requester/map-side signal bundle for map_arb. The slave modport is the arbiter;
// the master modport is whatever drives the requesters and models the map.
interface map_arb_if;
  logic [1:0] req;
  logic [1:0] cfg;
  logic [7:0] page0;
  logic [7:0] page1;
  logic [7:0] nfr0;
  logic [7:0] nfr1;
  logic [1:0] ack;
  logic       err;
  logic [7:0] frame_o;
  logic [1:0] gnt;
  logic       m_s_;
  logic       m_ad15;
  logic       m_rd;
  logic [7:0] m_cfg_page;
  logic [7:0] m_cfg_frame;
  logic [7:0] m_page;
  logic       m_cok;
  logic [7:0] m_frame;
  logic       m_pvalid;
  logic       m_reset_hold;

  modport slave (
    input  req, cfg, page0, page1, nfr0, nfr1,
    input  m_cok, m_frame, m_pvalid, m_reset_hold,
    output ack, err, frame_o, gnt,
    output m_s_, m_ad15, m_rd, m_cfg_page, m_cfg_frame, m_page
  );

  modport master (
    output req, cfg, page0, page1, nfr0, nfr1,
    output m_cok, m_frame, m_pvalid, m_reset_hold,
    input  ack, err, frame_o, gnt,
    input  m_s_, m_ad15, m_rd, m_cfg_page, m_cfg_frame, m_page
  );
endinterface

// File: rtl/map_arb.sv
// Two-master arbiter/sequencer in front of the page->frame map: grants one
// requester at a time and runs either a translate or a configure cycle on the map.
module map_arb #(
  parameter int CFG_TIMEOUT = 15,
  parameter int FAIR        = 1
) (
  input logic      clk,
  input logic      reset_,
  map_arb_if.slave bus
);

  localparam logic [7:0] TMO = 8'(CFG_TIMEOUT);

  typedef enum logic [2:0] {IDLE, TADDR, TDATA, CSTART, CWAIT, CREL} state_t;

  state_t     state;
  logic       win;
  logic       rr;
  logic       pend_err;
  logic [7:0] cnt;
  logic       any_req;
  logic       sel;
  logic [1:0] win_oh;

  // rr names the requester preferred when both are asking.
  always_comb begin
    any_req = |bus.req;
    sel     = 1'b0;
    if (FAIR != 0) sel = (&bus.req) ? rr : bus.req[1];
    else           sel = ~bus.req[0];
    win_oh  = win ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state           <= IDLE;
      win             <= 1'b0;
      rr              <= 1'b0;
      pend_err        <= 1'b0;
      cnt             <= '0;
      bus.ack         <= '0;
      bus.err         <= 1'b0;
      bus.frame_o     <= '0;
      bus.gnt         <= '0;
      bus.m_s_        <= 1'b1;
      bus.m_ad15      <= 1'b0;
      bus.m_rd        <= 1'b0;
      bus.m_page      <= '0;
      bus.m_cfg_page  <= '0;
      bus.m_cfg_frame <= '0;
    end else begin
      bus.ack <= '0;
      bus.err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req && !bus.m_reset_hold) begin
            win     <= sel;
            bus.gnt <= sel ? 2'b10 : 2'b01;
            if (bus.cfg[sel]) begin
              bus.m_cfg_page  <= sel ? bus.page1 : bus.page0;
              bus.m_cfg_frame <= sel ? bus.nfr1  : bus.nfr0;
              state           <= CSTART;
            end else begin
              bus.m_page <= sel ? bus.page1 : bus.page0;
              bus.m_rd   <= 1'b1;
              state      <= TADDR;
            end
          end
        end
        TADDR: state <= TDATA;
        TDATA: begin
          bus.frame_o <= bus.m_frame;
          bus.err     <= ~bus.m_pvalid;
          bus.ack     <= win_oh;
          bus.m_rd    <= 1'b0;
          bus.gnt     <= '0;
          rr          <= ~win;
          state       <= IDLE;
        end
        CSTART: begin
          bus.m_s_   <= 1'b0;
          bus.m_ad15 <= 1'b1;
          cnt        <= TMO;
          pend_err   <= 1'b0;
          state      <= CWAIT;
        end
        CWAIT: begin
          if (bus.m_cok) begin
            bus.m_s_   <= 1'b1;
            bus.m_ad15 <= 1'b0;
            state      <= CREL;
          end else begin
            cnt <= cnt - 8'd1;
            // The counter reaches zero on this edge: give up on cok.
            if (cnt == 8'd1) begin
              pend_err   <= 1'b1;
              bus.m_s_   <= 1'b1;
              bus.m_ad15 <= 1'b0;
              state      <= CREL;
            end
          end
        end
        CREL: begin
          if (!bus.m_cok) begin
            bus.ack  <= win_oh;
            bus.err  <= pend_err;
            pend_err <= 1'b0;
            bus.gnt  <= '0;
            rr       <= ~win;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
